// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: issues in-order word fetches under a credit limit and buffers
// returned instructions with their PCs for decode. A redirect flushes and drops in-flight data.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        iclk,
    input  logic        irst,
    output logic        oimem_req,
    output logic [31:0] oimem_addr,
    input  logic        iimem_gnt,
    input  logic        iimem_rvalid,
    input  logic [31:0] iimem_rdata,
    input  logic        iredirect,
    input  logic [31:0] iredirect_pc,
    output logic        ovalid,
    output logic [31:0] oinstr,
    output logic [31:0] opc,
    input  logic        iready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard;

    logic [CW:0]   occupancy;
    logic [31:0]   redirect_target;
    logic          grant;
    logic          rsp;
    logic          drop;
    logic          push;
    logic          pop;

    // Buffered plus outstanding requests bound the queue, so a push always finds space.
    assign occupancy       = {1'b0, count} + {1'b0, inflight};
    assign redirect_target = iredirect_pc & ~32'h0000_0003;

    assign oimem_req  = !irst && !iredirect && (occupancy < (CW + 1)'(DEPTH));
    assign oimem_addr = fetch_pc;

    assign grant = oimem_req && iimem_gnt;
    assign rsp   = iimem_rvalid && (inflight != '0);
    assign drop  = rsp && (discard != '0);
    assign push  = rsp && (discard == '0);
    assign pop   = ovalid && iready;

    assign ovalid = (count != '0);
    assign oinstr = ovalid ? q_instr[rptr] : NOP;
    assign opc    = ovalid ? q_pc[rptr]    : 32'h0000_0000;

    always_ff @(posedge iclk) begin
        if (push && !iredirect) begin
            q_pc[wptr]    <= resp_pc;
            q_instr[wptr] <= iimem_rdata;
        end
    end

    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            inflight <= '0;
            discard  <= '0;
        end else if (iredirect) begin
            // Every request not yet answered belongs to the old stream and must be dropped.
            fetch_pc <= redirect_target;
            resp_pc  <= redirect_target;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            inflight <= inflight - CW'(rsp);
            discard  <= inflight - CW'(rsp);
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if (push) begin
                resp_pc <= resp_pc + 32'd4;
                wptr    <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            if (drop) begin
                discard <= discard - CW'(1);
            end
            count    <= count + CW'(push) - CW'(pop);
            inflight <= inflight + CW'(grant) - CW'(rsp);
        end
    end

    always_ff @(posedge iclk) begin
        if (!irst) begin
            assert (occupancy <= (CW + 1)'(DEPTH))
                else $error("queue credit exceeded: count=%0d inflight=%0d", count, inflight);
            assert (discard <= inflight)
                else $error("discard %0d above inflight %0d", discard, inflight);
            assert (ovalid == (count != '0))
                else $error("ovalid disagrees with count %0d", count);
            assert (!(iimem_rvalid && (inflight == '0)))
                else $warning("response with nothing in flight ignored");
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with an in-order memory model of configurable latency.
module tb_instr_fetch_queue;

    logic        iclk;
    logic        irst;
    logic        oimem_req;
    logic [31:0] oimem_addr;
    logic        iimem_gnt;
    logic        iimem_rvalid;
    logic [31:0] iimem_rdata;
    logic        iredirect;
    logic [31:0] iredirect_pc;
    logic        ovalid;
    logic [31:0] oinstr;
    logic [31:0] opc;
    logic        iready;

    instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .iclk(iclk), .irst(irst),
        .oimem_req(oimem_req), .oimem_addr(oimem_addr), .iimem_gnt(iimem_gnt),
        .iimem_rvalid(iimem_rvalid), .iimem_rdata(iimem_rdata),
        .iredirect(iredirect), .iredirect_pc(iredirect_pc),
        .ovalid(ovalid), .oinstr(oinstr), .opc(opc), .iready(iready)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] gaddr[$];
    int          cyc;
    int          mem_lat;
    int          checks;
    int          failures;

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: record a grant seen before the edge, then present the next due response.
    task automatic tick();
        logic        g;
        logic [31:0] a;
        pend_t       p;
        #1;
        g = oimem_req & iimem_gnt;
        a = oimem_addr;
        @(posedge iclk);
        #1;
        cyc++;
        if (g) begin
            p.addr = a;
            p.due  = cyc + mem_lat - 1;
            pend.push_back(p);
            gaddr.push_back(a);
        end
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            iimem_rvalid = 1'b1;
            iimem_rdata  = word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            iimem_rvalid = 1'b0;
            iimem_rdata  = 32'h0;
        end
    endtask

    task automatic do_reset();
        irst         = 1'b1;
        iimem_gnt    = 1'b0;
        iready       = 1'b0;
        iredirect    = 1'b0;
        iredirect_pc = 32'h0;
        iimem_rvalid = 1'b0;
        iimem_rdata  = 32'h0;
        pend.delete();
        gaddr.delete();
        tick();
        irst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0; mem_lat = 1;
        irst = 1'b1; iimem_gnt = 1'b0; iready = 1'b0; iredirect = 1'b0;
        iredirect_pc = 32'h0; iimem_rvalid = 1'b0; iimem_rdata = 32'h0;

        // Test 1 / 5: reset values, then streaming at one instruction per cycle.
        tick(); tick();
        check("rst_req",   {31'b0, oimem_req}, 32'd0);
        check("rst_valid", {31'b0, ovalid},    32'd0);
        check("rst_instr", oinstr,             32'h0000_0013);
        check("rst_pc",    opc,                32'h0);
        check("rst_addr",  oimem_addr,         32'h0);
        irst = 1'b0; iimem_gnt = 1'b1; iready = 1'b1; mem_lat = 1;
        #1;
        check("t1_req_after_rel", {31'b0, oimem_req}, 32'd1);
        tick();
        check("t1_valid_early", {31'b0, ovalid}, 32'd0);
        tick();
        check("t1_valid_first", {31'b0, ovalid}, 32'd1);
        check("t1_pc0",    opc,    32'h0);
        check("t1_instr0", oinstr, word(32'h0));
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("t5_valid_held", {31'b0, ovalid}, 32'd1);
            check("t1_pc",    opc,    32'(4 * i));
            check("t1_instr", oinstr, word(32'(4 * i)));
        end

        // Test 2: backpressure fills exactly DEPTH entries, then drains in order.
        do_reset();
        mem_lat = 1; iimem_gnt = 1'b1; iready = 1'b0;
        repeat (8) tick();
        check("t2_grants", 32'(gaddr.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("t2_gaddr", (i < gaddr.size()) ? gaddr[i] : 32'hDEAD_DEAD, 32'(4 * i));
        check("t2_req_full", {31'b0, oimem_req}, 32'd0);
        check("t2_valid",    {31'b0, ovalid},    32'd1);
        check("t2_pc0",      opc,                32'h0);
        iready = 1'b1;
        tick();
        check("t2_req_resume", {31'b0, oimem_req}, 32'd1);
        check("t2_pc4", opc, 32'h4);
        tick();
        check("t2_pc8", opc, 32'h8);
        tick();
        check("t2_pcc", opc, 32'hC);
        check("t2_instrc", oinstr, word(32'hC));

        // Test 3: redirect with two requests outstanding drops both responses.
        do_reset();
        mem_lat = 3; iimem_gnt = 1'b1; iready = 1'b1;
        tick(); tick();
        iredirect = 1'b1; iredirect_pc = 32'h0000_0100;
        #1;
        check("t3_req_redirect", {31'b0, oimem_req}, 32'd0);
        tick();
        iredirect = 1'b0;
        #1;
        check("t3_addr_new", oimem_addr, 32'h100);
        for (int i = 0; i < 12 && !ovalid; i++) tick();
        check("t3_valid",  {31'b0, ovalid}, 32'd1);
        check("t3_pc",     opc,             32'h100);
        check("t3_instr",  oinstr,          word(32'h100));

        // Test 4: unaligned redirect target, and redirect while the queue is full.
        do_reset();
        mem_lat = 1; iimem_gnt = 1'b1; iready = 1'b1;
        repeat (3) tick();
        iredirect = 1'b1; iredirect_pc = 32'h0000_0103;
        tick();
        iredirect = 1'b0;
        #1;
        check("t4_addr_align", oimem_addr, 32'h100);
        check("t4_valid_flush", {31'b0, ovalid}, 32'd0);
        iready = 1'b0;
        repeat (8) tick();
        check("t4_full_valid", {31'b0, ovalid},    32'd1);
        check("t4_full_pc",    opc,                32'h100);
        check("t4_full_req",   {31'b0, oimem_req}, 32'd0);
        iredirect = 1'b1; iredirect_pc = 32'h0000_0200;
        tick();
        iredirect = 1'b0;
        #1;
        check("t4_flush_valid", {31'b0, ovalid}, 32'd0);
        check("t4_flush_instr", oinstr,          32'h0000_0013);
        check("t4_flush_pc",    opc,             32'h0);
        check("t4_flush_addr",  oimem_addr,      32'h200);

        // Test 6: reset mid-stream, late responses after release are ignored.
        do_reset();
        mem_lat = 3; iimem_gnt = 1'b1; iready = 1'b1;
        repeat (4) tick();
        check("t6_pre_valid", {31'b0, ovalid}, 32'd1);
        irst = 1'b1;
        #1;
        check("t6_rst_valid", {31'b0, ovalid},    32'd0);
        check("t6_rst_instr", oinstr,             32'h0000_0013);
        check("t6_rst_pc",    opc,                32'h0);
        check("t6_rst_req",   {31'b0, oimem_req}, 32'd0);
        check("t6_rst_addr",  oimem_addr,         32'h0);
        iimem_gnt = 1'b0;
        tick();
        irst = 1'b0;
        tick(); tick();
        check("t6_late_valid", {31'b0, ovalid},    32'd0);
        check("t6_late_req",   {31'b0, oimem_req}, 32'd1);
        check("t6_first_addr", oimem_addr,         32'h0);
        gaddr.delete();
        iimem_gnt = 1'b1; mem_lat = 1;
        tick();
        check("t6_gaddr", (gaddr.size() > 0) ? gaddr[0] : 32'hDEAD_DEAD, 32'h0);
        tick();
        check("t6_valid", {31'b0, ovalid}, 32'd1);
        check("t6_pc",    opc,             32'h0);
        check("t6_instr", oinstr,          word(32'h0));

        // PC wrap from the top of the address space back to zero.
        do_reset();
        mem_lat = 1; iimem_gnt = 1'b1; iready = 1'b1;
        iredirect = 1'b1; iredirect_pc = 32'hFFFF_FFF8;
        tick();
        iredirect = 1'b0;
        for (int i = 0; i < 6 && !ovalid; i++) tick();
        check("wrap_pc0", opc, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc1", opc, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc2",    opc,    32'h0);
        check("wrap_instr2", oinstr, word(32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
